// File: rtl/encoder_spi_slave.sv
// SPI mode-0 slave that reports the quadrature count relative to a zero offset
// and accepts a command word per frame; the pins are synchronized into clk.
//   state | meaning
//   IDLE  | deselected, waiting for chip select to fall
//   SHIFT | frame in progress, shifting count out and command in
//   DONE  | full word exchanged, extra sck edges ignored until deselect
module encoder_spi_slave #(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] CLEAR_CMD   = 16'hC1EA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] encoderCount,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rxWord,
  output logic             frameDone
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  FULL     = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_hist;
  logic                   r_cs_hist;
  logic [WIDTH-1:0]       r_tx_shift;
  logic [WIDTH-2:0]       r_rx_shift;
  logic [CW-1:0]          r_bit_count;
  logic [WIDTH-1:0]       r_snap_raw;
  logic [WIDTH-1:0]       r_zero_offset;
  logic [WIDTH-1:0]       r_rx_word;
  logic                   r_miso_oe;
  logic                   r_frame_done;

  logic             w_sck;
  logic             w_cs;
  logic             w_mosi;
  logic             w_sck_rise;
  logic             w_sck_fall;
  logic             w_cs_fall;
  logic             w_cs_rise;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rx_next;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise =  w_sck & ~r_sck_hist;
  assign w_sck_fall = ~w_sck &  r_sck_hist;
  assign w_cs_fall  = ~w_cs  &  r_cs_hist;
  assign w_cs_rise  =  w_cs  & ~r_cs_hist;
  assign w_diff     = encoderCount - r_zero_offset;
  assign w_rx_next  = {r_rx_shift, w_mosi};

  // miso is the registered MSB of the transmit shifter, cleared whenever it must idle low.
  assign miso      = r_tx_shift[WIDTH-1];
  assign miso_oe   = r_miso_oe;
  assign rxWord    = r_rx_word;
  assign frameDone = r_frame_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_sck_sync    <= '0;
      r_cs_sync     <= '1;
      r_mosi_sync   <= '0;
      r_sck_hist    <= 1'b0;
      r_cs_hist     <= 1'b1;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_bit_count   <= '0;
      r_snap_raw    <= '0;
      r_zero_offset <= '0;
      r_rx_word     <= '0;
      r_miso_oe     <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_sck_sync   <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync  <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sck_hist   <= w_sck;
      r_cs_hist    <= w_cs;
      r_miso_oe    <= ~w_cs;
      r_frame_done <= 1'b0;

      if (w_cs_rise) begin
        r_state    <= IDLE;
        r_tx_shift <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_cs_fall) begin
              r_state     <= SHIFT;
              r_snap_raw  <= encoderCount;
              r_tx_shift  <= w_diff;
              r_rx_shift  <= '0;
              r_bit_count <= '0;
            end
          end
          SHIFT: begin
            // An sck edge coinciding with a chip-select edge is dropped.
            if (!w_cs_fall) begin
              if (w_sck_rise) begin
                r_rx_shift  <= w_rx_next[WIDTH-2:0];
                r_bit_count <= r_bit_count + 1'b1;
                if (r_bit_count == LAST_BIT) begin
                  r_state      <= DONE;
                  r_tx_shift   <= '0;
                  r_rx_word    <= w_rx_next;
                  r_frame_done <= 1'b1;
                  if (w_rx_next == CLEAR_CMD) r_zero_offset <= r_snap_raw;
                end
              end else if (w_sck_fall && (r_bit_count < FULL)) begin
                r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
              end
            end
          end
          DONE: begin
            r_tx_shift <= '0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/encoder_spi_slave.md
Name: encoder_spi_slave

Overview:
- Downstream consumer of the quadrature counter's 16-bit `encoderCount`.
- Exposes the count to an external SPI master (mode 0, MSB first) over asynchronous SCK/CS_n/MOSI pins.
- Each frame snapshots the count, shifts it out, and simultaneously shifts in a command word. One command re-zeroes the reported position through an internal offset.
- All logic runs in the `clk` domain; the SPI pins are synchronized and edge-detected internally.

Parameters:
- WIDTH, 16, frame length in bits; equals the counter width.
- SYNC_STAGES, 2, flip-flop stages on each of sck/cs_n/mosi (minimum 2).
- CLEAR_CMD, 16'hC1EA, received word that sets the zero offset.

Ports:
- clk  input  1  system clock; must be ≥ 8× SCK frequency.
- reset  input  1  synchronous, active-high reset.
- encoderCount  input  WIDTH  raw count from the quadrature counter, already in the clk domain.
- sck  input  1  SPI clock, asynchronous, idles low.
- cs_n  input  1  SPI chip select, asynchronous, active low.
- mosi  input  1  SPI data in, asynchronous.
- miso  output  1  SPI data out.
- miso_oe  output  1  high while selected; drives the external tristate.
- rxWord  output  WIDTH  last completely received command word.
- frameDone  output  1  one-cycle pulse on completion of a full frame.

Behaviour:
- Synchronizers:
  - sck, cs_n and mosi each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Reset values: sck chain 0, cs_n chain 1, mosi chain 0.
  - sckRise/sckFall/csFall/csRise are single-cycle strobes derived from the synchronized value and its history flop.
- Reset:
  - State IDLE; txShift, rxShift, bitCount, zeroOffset and rxWord all 0.
  - miso 0, miso_oe 0, frameDone 0.
  - Reset asserted mid-frame aborts the frame immediately; no frameDone, zeroOffset is cleared.
- State machine (IDLE, SHIFT, DONE):
  - IDLE, on csFall → SHIFT.
    - snapRaw <= encoderCount.
    - txShift <= encoderCount − zeroOffset (mod 2^WIDTH).
    - bitCount <= 0; miso <= MSB of that difference.
  - SHIFT, on sckRise: rxShift <= {rxShift[WIDTH-2:0], mosi_sync}; bitCount++.
  - SHIFT, on sckFall with bitCount < WIDTH: txShift shifts left one bit; miso <= new MSB.
  - SHIFT, on the sckRise that makes bitCount == WIDTH → DONE.
    - rxWord <= completed word; frameDone = 1 for exactly that cycle.
    - If completed word == CLEAR_CMD: zeroOffset <= snapRaw.
  - DONE: all sck edges are ignored; miso holds 0.
  - SHIFT or DONE, on csRise → IDLE; miso <= 0.
    - If aborted from SHIFT: no frameDone; rxWord and zeroOffset unchanged.
- Outputs:
  - miso_oe = inverted synchronized cs_n, registered.
  - miso is registered.
- Priorities:
  - reset > csRise > csFall > sck edges.
  - An sck edge in the same cycle as csFall or csRise is discarded.
- Latency:
  - cs_n pin falling → miso/miso_oe valid after SYNC_STAGES+2 clk cycles.
  - Pin sck edge → miso update after SYNC_STAGES+2 clk cycles.
  - The master must allow this before its first SCK rise (≥ 4 clk at defaults).
- Arithmetic:
  - The reported value is the modular WIDTH-bit difference; e.g. raw 0x0002 with offset 0x0005 reports 0xFFFD.
  - zeroOffset takes effect from the next frame's snapshot, never the current one.
- Count changes during a frame do not alter shifted data; the snapshot is taken only at csFall.
- More than WIDTH sck pulses in one frame: extra pulses are ignored in DONE and the master reads 0.

Test Plan:
- Reset, then encoderCount=16'h1234, full 16-bit frame with mosi=0 → miso bits 0001_0010_0011_0100 MSB-first, frameDone pulses once, rxWord=0x0000.
- encoderCount=0x0100, frame with mosi=0xC1EA → that frame reads 0x0100 and zeroOffset becomes 0x0100. Count then moves to 0x00FE; next frame reads 0xFFFE.
- encoderCount changes 0x0010→0x0011 between the 8th and 9th SCK → frame reads 0x0010 intact.
- cs_n deasserted after 7 SCK cycles carrying mosi=0xC1EA's first bits → no frameDone, rxWord and zeroOffset unchanged, miso=0, miso_oe=0. The next full frame is correct.
- 20 SCK pulses in one frame with count 0xFFFF → first 16 bits all 1, the remaining 4 read 0, frameDone exactly once.
- Reset asserted mid-frame after a prior clear command → miso_oe=0 until the next csFall; the next frame reads the raw count, with offset cleared.
